fp_mul_round_pack: RTL and testbench

Back end of the FPU single-precision multiply path. Takes the raw 48-bit significand product, the pre-normalisation exponent and the upstream error flag. Normalises the product, derives guard/round/sticky bits and applies the selected IEEE rounding mode. Packs the 32-bit result with exception flags through a 2-stage valid/ready pipeline.

---
 rtl/fpu_pkg.sv | 20 ++
 rtl/fp_grs_extract.sv | 32 +++
 rtl/fp_mul_round_pack.sv | 141 ++++++++++++++
 tb/tb_fp_mul_round_pack.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU constants: rounding-mode encodings, special results and field widths.
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int XEXP_W = 10;
  localparam int SIG_W  = FRAC_W + 1;
  localparam int PROD_W = 2 * FRAC_W + 2;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  localparam int          EXP_MAX  = 255;
  localparam logic [31:0] QNAN     = 32'h7FC00000;
  localparam logic [30:0] INF_MAG  = 31'h7F800000;
  localparam logic [30:0] MAX_MAG  = 31'h7F7FFFFF;

endpackage

// File: rtl/fp_grs_extract.sv
// Combinational normalise of a 2.46 significand product into 1.23 mantissa plus round/sticky.
// A product >= 2.0 shifts right by one and bumps the exponent.
module fp_grs_extract #(
  parameter int FRAC_W = 23,
  parameter int XEXP_W = 10
) (
  input  logic [2*FRAC_W+1:0]      prod,
  input  logic signed [XEXP_W-1:0] bexp,
  output logic [FRAC_W:0]          mant,
  output logic                     r,
  output logic                     s,
  output logic signed [XEXP_W:0]   norm_exp
);

  logic shift;

  always_comb begin
    shift = prod[2*FRAC_W+1];
    if (shift) begin
      mant = prod[2*FRAC_W+1:FRAC_W+1];
      r    = prod[FRAC_W];
      s    = |prod[FRAC_W-1:0];
    end else begin
      mant = prod[2*FRAC_W:FRAC_W];
      r    = prod[FRAC_W-1];
      s    = |prod[FRAC_W-2:0];
    end
    // one extra bit so in_exp+1 cannot wrap
    norm_exp = {bexp[XEXP_W-1], bexp} + {{XEXP_W{1'b0}}, shift};
  end

endmodule

// File: rtl/fp_mul_round_pack.sv
// FP multiply back end: normalise/GRS (S1), round + exception pack (S2); 2-cycle latency, 1/cycle.
// Both stages stall together while the output is valid and not taken; in_ready mirrors that.
module fp_mul_round_pack
  import fpu_pkg::*;
#(
  parameter int EXP_W  = fpu_pkg::EXP_W,
  parameter int FRAC_W = fpu_pkg::FRAC_W,
  parameter int XEXP_W = fpu_pkg::XEXP_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sign,
  input  logic [XEXP_W-1:0]     in_exp,
  input  logic [2*FRAC_W+1:0]   in_prod,
  input  logic                  in_rerror,
  input  logic [1:0]            in_rmode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_result,
  output logic                  out_overflow,
  output logic                  out_underflow,
  output logic                  out_inexact,
  output logic                  out_invalid
);

  localparam int SW = FRAC_W + 1;
  localparam int EW = XEXP_W + 2;
  localparam logic signed [EW-1:0] EXP_OVF = EW'(EXP_MAX);
  localparam logic signed [EW-1:0] EXP_UNF = '0;

  logic advance;

  logic                   g_r, g_s;
  logic [SW-1:0]          g_mant;
  logic signed [XEXP_W:0] g_exp;

  logic                   s1_valid, s1_sign, s1_rerror, s1_r, s1_s;
  logic [1:0]             s1_rmode;
  logic [SW-1:0]          s1_mant;
  logic signed [XEXP_W:0] s1_exp;

  logic                   inc, to_inf;
  logic [SW:0]            sum;
  logic [FRAC_W-1:0]      frac_r;
  logic signed [EW-1:0]   exp_r;
  logic [31:0]            res_d;
  logic                   ovf_d, unf_d, inx_d, inv_d;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  fp_grs_extract #(
    .FRAC_W (FRAC_W),
    .XEXP_W (XEXP_W)
  ) u_grs (
    .prod     (in_prod),
    .bexp     ($signed(in_exp)),
    .mant     (g_mant),
    .r        (g_r),
    .s        (g_s),
    .norm_exp (g_exp)
  );

  always_comb begin
    inc = 1'b0;
    case (s1_rmode)
      RM_RNE:  inc = s1_r & (s1_s | s1_mant[0]);
      RM_RUP:  inc = ~s1_sign & (s1_r | s1_s);
      RM_RDN:  inc = s1_sign & (s1_r | s1_s);
      default: inc = 1'b0;
    endcase

    sum = {1'b0, s1_mant} + {{SW{1'b0}}, inc};
    // carry out of the significand renormalises to 1.0 and bumps the exponent
    frac_r = sum[SW] ? sum[FRAC_W:1] : sum[FRAC_W-1:0];
    exp_r  = {s1_exp[XEXP_W], s1_exp} + {{(EW-1){1'b0}}, sum[SW]};

    to_inf = (s1_rmode == RM_RNE) | ((s1_rmode == RM_RUP) & ~s1_sign) |
             ((s1_rmode == RM_RDN) & s1_sign);

    res_d = {s1_sign, exp_r[EXP_W-1:0], frac_r};
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inx_d = s1_r | s1_s;
    inv_d = 1'b0;
    if (s1_rerror) begin
      res_d = QNAN;
      inx_d = 1'b0;
      inv_d = 1'b1;
    end else if (exp_r >= EXP_OVF) begin
      res_d = {s1_sign, to_inf ? INF_MAG : MAX_MAG};
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end else if (exp_r <= EXP_UNF) begin
      res_d = {s1_sign, 31'b0};
      unf_d = 1'b1;
      inx_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid      <= 1'b0;
      s1_sign       <= 1'b0;
      s1_rerror     <= 1'b0;
      s1_rmode      <= 2'b00;
      s1_mant       <= '0;
      s1_r          <= 1'b0;
      s1_s          <= 1'b0;
      s1_exp        <= '0;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact   <= 1'b0;
      out_invalid   <= 1'b0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign   <= in_sign;
        s1_rerror <= in_rerror;
        s1_rmode  <= in_rmode;
        s1_mant   <= g_mant;
        s1_r      <= g_r;
        s1_s      <= g_s;
        s1_exp    <= g_exp;
      end
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result    <= res_d;
        out_overflow  <= ovf_d;
        out_underflow <= unf_d;
        out_inexact   <= inx_d;
        out_invalid   <= inv_d;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_round_pack.sv
// Directed and randomized checks of fp_mul_round_pack against an arithmetic rounding model.
module tb_fp_mul_round_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sign, in_rerror;
  logic [9:0]  in_exp;
  logic [47:0] in_prod;
  logic [1:0]  in_rmode;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_overflow, out_underflow, out_inexact, out_invalid;

  int passed = 0;
  int total  = 0;

  logic [35:0] exp_q[$];
  string       tag_q[$];
  bit          use_dir = 1'b0;
  logic [35:0] dir_exp;
  string       cur_tag = "rand";

  always #5 clk = ~clk;

  fp_mul_round_pack dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_prod       (in_prod),
    .in_rerror     (in_rerror),
    .in_rmode      (in_rmode),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_inexact   (out_inexact),
    .out_invalid   (out_invalid)
  );

  function automatic logic [35:0] obs();
    return {out_result, out_overflow, out_underflow, out_inexact, out_invalid};
  endfunction

  // Value-level reference: round the exact product by comparing the discarded remainder with half an ulp.
  function automatic logic [35:0] model(bit sign, int e_in, logic [47:0] p, bit rerr, logic [1:0] rm);
    longint unsigned m, rem, half;
    int e;
    bit up, inx, toward_inf;
    logic [7:0] e8;
    if (rerr) return {32'h7FC00000, 4'b0001};
    if (p[47]) begin
      m = p >> 24; rem = p % (64'd1 << 24); half = 64'd1 << 23; e = e_in + 1;
    end else begin
      m = p >> 23; rem = p % (64'd1 << 23); half = 64'd1 << 22; e = e_in;
    end
    case (rm)
      2'b00:   up = (rem > half) || (rem == half && (m % 2) == 1);
      2'b10:   up = !sign && rem != 0;
      2'b11:   up = sign && rem != 0;
      default: up = 1'b0;
    endcase
    m = m + (up ? 1 : 0);
    if (m == (64'd1 << 24)) begin
      m = m / 2; e = e + 1;
    end
    inx = (rem != 0);
    if (e >= 255) begin
      toward_inf = (rm == 2'b00) || (rm == 2'b10 && !sign) || (rm == 2'b11 && sign);
      return {sign, toward_inf ? 31'h7F800000 : 31'h7F7FFFFF, 4'b1010};
    end
    if (e <= 0) return {sign, 31'b0, 4'b0110};
    e8 = e[7:0];
    return {sign, e8, m[22:0], 1'b0, 1'b0, inx, 1'b0};
  endfunction

  task automatic check(string tag, logic [35:0] o, logic [35:0] e);
    total++;
    assert (o === e) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // One cycle: settle, score any output transfer, record any input transfer, advance to next negedge.
  task automatic step();
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("spurious_out", {35'b0, out_valid}, 36'd0);
      else check(tag_q.pop_front(), obs(), exp_q.pop_front());
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(use_dir ? dir_exp : model(in_sign, $signed(in_exp), in_prod, in_rerror, in_rmode));
      tag_q.push_back(cur_tag);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(bit s, int e, logic [47:0] p, bit rerr, logic [1:0] rm);
    in_sign = s; in_exp = e[9:0]; in_prod = p; in_rerror = rerr; in_rmode = rm;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
    if (exp_q.size() != 0) check("drain_timeout", 36'(exp_q.size()), 36'd0);
  endtask

  task automatic directed(string tag, bit s, int e, logic [47:0] p, bit rerr, logic [1:0] rm,
                          logic [35:0] expv);
    drive(s, e, p, rerr, rm);
    in_valid = 1'b1; out_ready = 1'b1;
    use_dir = 1'b1; dir_exp = expv; cur_tag = tag;
    step();
    in_valid = 1'b0; use_dir = 1'b0; cur_tag = "rand";
    drain();
  endtask

  task automatic rand_beat();
    logic [47:0] p;
    int e;
    p = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
    if (!p[47]) p[46] = 1'b1;
    if ($urandom_range(0, 3) == 0) p[21:0] = '0;
    e = int'($urandom_range(0, 290)) - 12;
    drive($urandom_range(0, 1) == 1, e, p, $urandom_range(0, 15) == 0, 2'($urandom_range(0, 3)));
  endtask

  initial begin
    logic [35:0] held;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(1'b0, 0, 48'h0, 1'b0, 2'b00);
    repeat (3) @(negedge clk);
    #1;
    check("reset_out", {obs(), out_valid}, 37'd0);
    check("reset_in_ready", {35'b0, in_ready}, 36'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // 1.5*1.5 with latency checks
    drive(1'b0, 127, 48'h900000000000, 1'b0, 2'b00);
    in_valid = 1'b1; use_dir = 1'b1; dir_exp = {32'h40100000, 4'b0000}; cur_tag = "mul_1p5";
    step();
    in_valid = 1'b0; use_dir = 1'b0; cur_tag = "rand";
    #1 check("lat_cycle1", {35'b0, out_valid}, 36'd0);
    step();
    #1 check("lat_cycle2", {35'b0, out_valid}, 36'd1);
    drain();

    directed("tie_even",   1'b0, 127, 48'h400000400000, 1'b0, 2'b00, {32'h3F800000, 4'b0010});
    directed("tie_odd",    1'b0, 127, 48'h400000C00000, 1'b0, 2'b00, {32'h3F800002, 4'b0010});
    directed("rnd_carry",  1'b0, 127, 48'h7FFFFFC00000, 1'b0, 2'b00, {32'h40000000, 4'b0010});
    directed("ovf_rne",    1'b0, 254, 48'h800000000000, 1'b0, 2'b00, {32'h7F800000, 4'b1010});
    directed("ovf_rtz",    1'b0, 254, 48'h800000000000, 1'b0, 2'b01, {32'h7F7FFFFF, 4'b1010});
    directed("ovf_rdn_n",  1'b1, 254, 48'h800000000000, 1'b0, 2'b11, {32'hFF800000, 4'b1010});
    directed("ovf_rup_n",  1'b1, 254, 48'h800000000000, 1'b0, 2'b10, {32'hFF7FFFFF, 4'b1010});
    directed("ovf_rdn_p",  1'b0, 254, 48'h800000000000, 1'b0, 2'b11, {32'h7F7FFFFF, 4'b1010});
    directed("unf_zero",   1'b0, 0,   48'h400000000000, 1'b0, 2'b00, {32'h00000000, 4'b0110});
    directed("unf_neg",    1'b1, -3,  48'h400000000000, 1'b0, 2'b01, {32'h80000000, 4'b0110});
    directed("rerror",     1'b1, 127, 48'h900000000000, 1'b1, 2'b00, {32'h7FC00000, 4'b0001});
    directed("rup_pos",    1'b0, 127, 48'h400000000001, 1'b0, 2'b10, {32'h3F800001, 4'b0010});
    directed("rtz_trunc",  1'b0, 127, 48'h7FFFFFFFFFFF, 1'b0, 2'b01, {32'h3FFFFFFF, 4'b0010});

    // backpressure: four beats stream, then a 3-cycle stall with a pending fifth beat
    cur_tag = "bp_stream";
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_beat(); in_rerror = 1'b0; in_valid = 1'b1;
      step();
    end
    rand_beat(); in_valid = 1'b1; out_ready = 1'b0;
    #1 held = obs();
    check("bp_in_ready", {34'b0, in_ready, out_valid}, 36'd1);
    step();
    for (int i = 0; i < 2; i++) begin
      #1;
      check("bp_hold", obs(), held);
      check("bp_in_ready", {34'b0, in_ready, out_valid}, 36'd1);
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    drain();
    cur_tag = "rand";

    // reset with two beats in flight
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rand_beat(); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_flush", {34'b0, out_valid, in_ready}, 36'd1);
    exp_q.delete(); tag_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check("rst_no_stale", {35'b0, out_valid}, 36'd0);
      step();
    end

    // randomized stream with random stalls
    for (int i = 0; i < 400; i++) begin
      rand_beat();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
